mc_ctrl: RTL and testbench
==========================

// Module: mc_ctrl
// PURPOSE
// Multi-cycle main controller for the MIPS core: steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
// Drives every datapath control: PC, IR, immediate extender type, ALU, memory, register file.
// Waits on a shared memory ready handshake and aborts an access that times out.
// Sits between the instruction/data memory port and the datapath.
// PARAMETERS
// MAX_WAIT  255  cycles a memory request may wait for MemReady before BusErr abort (1..255)
// PORTS
// clk        in   1   system clock, rising edge
// reset      in   1   asynchronous, active-high reset
// Instr      in   32  memory read data; opcode/funct latched internally on IRWr
// Zero       in   1   ALU equal flag, sampled in EXEC for beq
// MemReady   in   1   memory completes current read/write this cycle
// PCWr       out  1   PC load enable
// PCSel      out  2   00 PC+4, 01 branch target, 10 jump {PC[31:28],idx,2'b0}, 11 GPR[rs]
// IRWr       out  1   IR load enable
// IorD       out  1   0 instruction address (PC), 1 data address (ALU result)
// MemRd      out  1   memory read request
// MemWr      out  1   memory write request
// EXTType    out  4   0000 zero-extend, 0001 sign-extend, 0010 imm16<<16
// ALUSrcB    out  1   0 GPR[rt], 1 extended immediate
// ALUOp      out  4   0000 add, 0001 sub, 0010 or, 0011 pass-B
// RegWr      out  1   GPR write enable
// RegDst     out  2   00 rt, 01 rd, 10 $31
// WDSel      out  2   00 ALU result, 01 memory data, 10 PC (link)
// Illegal    out  1   one-cycle pulse in DECODE on an unsupported opcode/funct
// BusErr     out  1   one-cycle pulse on MemReady timeout
// BEHAVIOUR
// - Reset (async, any state): state=FETCH; wait counter=0; latched op/funct=0.
//   All outputs 0; EXTType=0000.
// - Supported: addu/subu/jr (op 00, funct 21/23/08), ori 0D, lui 0F, lw 23, sw 2B, beq 04, j 02, jal 03.
// - FETCH: IorD=0, MemRd=1 until MemReady.
//   On MemReady: IRWr=1, PCWr=1, PCSel=00, latch Instr[31:26]/[5:0] -> DECODE.
// - DECODE: j -> PCWr, PCSel=10 -> FETCH.
//   jal -> also RegWr, RegDst=10, WDSel=10 -> FETCH.
//   Unsupported -> Illegal pulse, no writes (nop) -> FETCH. Others -> EXEC.
// - EXEC: addu/subu/ori/lui -> WB. lw/sw -> MEM (address compute).
//   beq -> PCWr=Zero, PCSel=01 -> FETCH. jr -> PCWr, PCSel=11 -> FETCH.
// - MEM: IorD=1; lw MemRd=1, sw MemWr=1, held until MemReady; lw -> WB, sw -> FETCH.
// - WB: RegWr=1 one cycle; R-type RegDst=01, else 00; lw WDSel=01, else 00 -> FETCH.
// - Latency with MemReady=1 immediately:
//   j/jal 2, beq/jr 3, addu/subu/ori/lui/sw 4, lw 5 cycles.
// - EXTType: pure function of latched opcode, stable DECODE..WB.
//   ori 0000, lw/sw/beq 0001, lui 0010, all others 0000.
// - ALUOp/ALUSrcB: function of latched opcode/funct, stable DECODE..WB.
//   addu, lw, sw: add. subu, beq: sub. ori: or. lui: pass-B.
//   ALUSrcB=1 for ori/lui/lw/sw.
// - Wait counter: cleared on entry to FETCH/MEM, increments each cycle MemReady=0.
//   Reaches MAX_WAIT -> BusErr pulse, drop request, no IRWr/PCWr/RegWr -> FETCH.
//   In FETCH the PC is not advanced, so the same fetch retries.
//   MemReady in the same cycle counter hits MAX_WAIT: completion wins, no BusErr.
// - At most one of MemRd/MemWr high; never both RegWr and MemWr.
// - Reset mid-MEM: write request drops asynchronously; no partial RegWr/PCWr.
// STRUCTURE
// - Shared include mc_defs.vh: opcode/funct codes, EXTType codes, PCSel/RegDst/WDSel/ALUOp codes,
//   state encodings (3-bit).
// - Sub-module mc_decode (combinational): latched op/funct -> instr class, EXTType, ALUOp, ALUSrcB, Illegal.
// - mc_ctrl holds the FSM, op/funct registers, wait counter and per-state output logic.
// TESTING
// - ori (op 0D), MemReady=1 -> EXTType=0000 and ALUOp=0010 in EXEC; RegWr=1, RegDst=00 in cycle 4 only.
// - lui (op 0F) -> EXTType=0010 and ALUOp=0011 in EXEC; WB cycle 4.
//   lw (op 23) -> EXTType=0001, MemRd with IorD=1 in cycle 4; RegWr with WDSel=01 in cycle 5.
// - beq (op 04): Zero=1 -> PCWr=1, PCSel=01 in cycle 3.
//   Zero=0 -> PCWr=0; next cycle FETCH.
// - jal (op 03) -> cycle 2: PCWr=1, PCSel=10, RegWr=1, RegDst=10, WDSel=10; cycle 3 MemRd (FETCH).
// - sw with MemReady held 0 for 255 cycles -> BusErr pulse once, MemWr drops, FETCH next.
//   Repeat with MemReady=1 on cycle 255 -> no BusErr.
// - op 3F -> Illegal pulse in DECODE, zero writes. Reset asserted mid-MEM of sw -> MemWr=0 immediately;
//   after release, FETCH with MemRd=1.

Source files
------------

// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS main controller.
// Holds the opcode/funct codes it recognises, the control-field encodings
// driven onto the datapath, the 3-bit FSM state encoding and the internal
// instruction class produced by the decoder.
package mc_ctrl_pkg;

    // Primary opcodes (Instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type function codes (Instr[5:0])
    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    // Immediate extender selection
    localparam logic [3:0] EXT_ZERO = 4'b0000;
    localparam logic [3:0] EXT_SIGN = 4'b0001;
    localparam logic [3:0] EXT_LUI  = 4'b0010;

    // PC source selection
    localparam logic [1:0] PCSEL_PC4    = 2'b00;
    localparam logic [1:0] PCSEL_BRANCH = 2'b01;
    localparam logic [1:0] PCSEL_JUMP   = 2'b10;
    localparam logic [1:0] PCSEL_REG    = 2'b11;

    // Register-file destination selection
    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_RA = 2'b10;

    // Register-file write-data selection
    localparam logic [1:0] WDSEL_ALU = 2'b00;
    localparam logic [1:0] WDSEL_MEM = 2'b01;
    localparam logic [1:0] WDSEL_PC  = 2'b10;

    // ALU operation
    localparam logic [3:0] ALU_ADD   = 4'b0000;
    localparam logic [3:0] ALU_SUB   = 4'b0001;
    localparam logic [3:0] ALU_OR    = 4'b0010;
    localparam logic [3:0] ALU_PASSB = 4'b0011;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4
    } state_e;

    typedef enum logic [3:0] {
        CLS_ILLEGAL = 4'd0,
        CLS_ADDU,
        CLS_SUBU,
        CLS_JR,
        CLS_ORI,
        CLS_LUI,
        CLS_LW,
        CLS_SW,
        CLS_BEQ,
        CLS_J,
        CLS_JAL
    } instr_class_e;

    // R-type results are written to rd rather than rt.
    function automatic logic is_rtype(input instr_class_e cls);
        return cls inside {CLS_ADDU, CLS_SUBU, CLS_JR};
    endfunction

endpackage

// File: rtl/mc_decode.sv
// Combinational instruction decoder for the multi-cycle controller.
// Maps the latched opcode/funct pair to an instruction class and to the
// datapath fields that depend only on the instruction (extender type,
// ALU operation, ALU B-operand source), plus an unsupported-encoding flag.
// Ports:
//   op, funct  in   latched Instr[31:26] / Instr[5:0]
//   cls        out  instruction class
//   ext_type   out  immediate extender selection
//   alu_op     out  ALU operation
//   alu_src_b  out  0 GPR[rt], 1 extended immediate
//   illegal    out  encoding is not supported
module mc_decode
    import mc_ctrl_pkg::*;
(
    input  logic [5:0]   op,
    input  logic [5:0]   funct,
    output instr_class_e cls,
    output logic [3:0]   ext_type,
    output logic [3:0]   alu_op,
    output logic         alu_src_b,
    output logic         illegal
);

    always_comb begin
        // NOTE: every signal assigned in a combinational block gets a default first, so no path infers a latch.
        cls = CLS_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                case (funct)
                    FN_ADDU: cls = CLS_ADDU;
                    FN_SUBU: cls = CLS_SUBU;
                    FN_JR:   cls = CLS_JR;
                    default: cls = CLS_ILLEGAL;
                endcase
            end
            OP_ORI:  cls = CLS_ORI;
            OP_LUI:  cls = CLS_LUI;
            OP_LW:   cls = CLS_LW;
            OP_SW:   cls = CLS_SW;
            OP_BEQ:  cls = CLS_BEQ;
            OP_J:    cls = CLS_J;
            OP_JAL:  cls = CLS_JAL;
            default: cls = CLS_ILLEGAL;
        endcase
    end

    always_comb begin
        ext_type  = EXT_ZERO;
        alu_op    = ALU_ADD;
        alu_src_b = 1'b0;
        case (cls)
            CLS_ADDU: alu_op = ALU_ADD;
            CLS_SUBU: alu_op = ALU_SUB;
            CLS_ORI: begin
                ext_type  = EXT_ZERO;
                alu_op    = ALU_OR;
                alu_src_b = 1'b1;
            end
            CLS_LUI: begin
                ext_type  = EXT_LUI;
                alu_op    = ALU_PASSB;
                alu_src_b = 1'b1;
            end
            CLS_LW, CLS_SW: begin
                ext_type  = EXT_SIGN;
                alu_op    = ALU_ADD;
                alu_src_b = 1'b1;
            end
            // beq compares rs against rt, so B stays on the register operand.
            CLS_BEQ: begin
                ext_type = EXT_SIGN;
                alu_op   = ALU_SUB;
            end
            default: begin
                ext_type  = EXT_ZERO;
                alu_op    = ALU_ADD;
                alu_src_b = 1'b0;
            end
        endcase
    end

    assign illegal = (cls == CLS_ILLEGAL);

endmodule

// File: rtl/mc_ctrl.sv
// Multi-cycle main controller for the MIPS core.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// PC, IR, immediate extender, ALU, memory and register-file controls.
// Memory accesses wait on MemReady; an access still pending after MAX_WAIT
// cycles is dropped with a one-cycle BusErr pulse and control returns to FETCH.
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   Instr        memory read data; opcode/funct latched when IRWr fires
//   Zero         ALU equal flag, used by beq in EXEC
//   MemReady     memory completes the current read/write this cycle
//   PCWr/PCSel   PC load enable / source (PC+4, branch, jump, GPR[rs])
//   IRWr, IorD   IR load enable, memory address select (PC / ALU result)
//   MemRd/MemWr  memory read / write request
//   EXTType, ALUSrcB, ALUOp   instruction-dependent datapath fields
//   RegWr/RegDst/WDSel        register-file write enable / dest / data select
//   Illegal      one-cycle pulse in DECODE on an unsupported encoding
//   BusErr       one-cycle pulse when a memory request times out
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    input  logic        MemReady,
    output logic        PCWr,
    output logic [1:0]  PCSel,
    output logic        IRWr,
    output logic        IorD,
    output logic        MemRd,
    output logic        MemWr,
    output logic [3:0]  EXTType,
    output logic        ALUSrcB,
    output logic [3:0]  ALUOp,
    output logic        RegWr,
    output logic [1:0]  RegDst,
    output logic [1:0]  WDSel,
    output logic        Illegal,
    output logic        BusErr
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    state_e       state_q, state_d;
    logic [7:0]   wait_cnt_q, wait_cnt_d;
    logic [5:0]   op_q, op_d;
    logic [5:0]   funct_q, funct_d;

    instr_class_e cls;
    logic         dec_illegal;
    logic [7:0]   wait_cnt_inc;
    logic         timeout;

    // Only opcode and funct are needed here; the datapath owns the other fields.
    logic         unused_instr_bits;
    assign unused_instr_bits = ^Instr[25:6];

    mc_decode u_decode (
        .op        (op_q),
        .funct     (funct_q),
        .cls       (cls),
        .ext_type  (EXTType),
        .alu_op    (ALUOp),
        .alu_src_b (ALUSrcB),
        .illegal   (dec_illegal)
    );

    // The counter holds the number of idle cycles already seen; this cycle is
    // the MAX_WAIT-th idle one when the increment lands on the limit.  A
    // MemReady in that same cycle is handled first, so completion wins.
    assign wait_cnt_inc = wait_cnt_q + 8'd1;
    assign timeout      = !MemReady && (wait_cnt_inc == WAIT_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_FETCH;
            wait_cnt_q <= '0;
            op_q       <= '0;
            funct_q    <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            op_q       <= op_d;
            funct_q    <= funct_d;
        end
    end

    // Outputs are decoded from the current state rather than registered:
    // IRWr/PCWr/BusErr must answer MemReady in the same cycle, and gating
    // with reset makes every request drop the moment reset asserts.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = '0;
        op_d       = op_q;
        funct_d    = funct_q;

        PCWr    = 1'b0;
        PCSel   = PCSEL_PC4;
        IRWr    = 1'b0;
        IorD    = 1'b0;
        MemRd   = 1'b0;
        MemWr   = 1'b0;
        RegWr   = 1'b0;
        RegDst  = REGDST_RT;
        WDSel   = WDSEL_ALU;
        Illegal = 1'b0;
        BusErr  = 1'b0;

        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    MemRd = 1'b1;
                    if (MemReady) begin
                        IRWr    = 1'b1;
                        PCWr    = 1'b1;
                        op_d    = Instr[31:26];
                        funct_d = Instr[5:0];
                        state_d = ST_DECODE;
                    end else if (timeout) begin
                        // PC is left alone so the same fetch is retried.
                        BusErr  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        wait_cnt_d = wait_cnt_inc;
                    end
                end

                ST_DECODE: begin
                    if (dec_illegal) begin
                        Illegal = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        case (cls)
                            CLS_J: begin
                                PCWr    = 1'b1;
                                PCSel   = PCSEL_JUMP;
                                state_d = ST_FETCH;
                            end
                            CLS_JAL: begin
                                PCWr    = 1'b1;
                                PCSel   = PCSEL_JUMP;
                                RegWr   = 1'b1;
                                RegDst  = REGDST_RA;
                                WDSel   = WDSEL_PC;
                                state_d = ST_FETCH;
                            end
                            default: state_d = ST_EXEC;
                        endcase
                    end
                end

                ST_EXEC: begin
                    case (cls)
                        CLS_LW, CLS_SW: state_d = ST_MEM;
                        CLS_BEQ: begin
                            PCWr    = Zero;
                            PCSel   = PCSEL_BRANCH;
                            state_d = ST_FETCH;
                        end
                        CLS_JR: begin
                            PCWr    = 1'b1;
                            PCSel   = PCSEL_REG;
                            state_d = ST_FETCH;
                        end
                        default: state_d = ST_WB;
                    endcase
                end

                ST_MEM: begin
                    IorD  = 1'b1;
                    MemRd = (cls == CLS_LW);
                    MemWr = (cls == CLS_SW);
                    if (MemReady) begin
                        state_d = (cls == CLS_LW) ? ST_WB : ST_FETCH;
                    end else if (timeout) begin
                        BusErr  = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        wait_cnt_d = wait_cnt_inc;
                    end
                end

                ST_WB: begin
                    RegWr   = 1'b1;
                    RegDst  = is_rtype(cls) ? REGDST_RD : REGDST_RT;
                    WDSel   = (cls == CLS_LW) ? WDSEL_MEM : WDSEL_ALU;
                    state_d = ST_FETCH;
                end

                default: state_d = ST_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl.
// Each directed step drives the inputs for one clock cycle and pushes the
// outputs that cycle must show onto a scoreboard queue; a negedge monitor
// pops the entry and compares it against the DUT under a field mask.
module tb_mc_ctrl;

    localparam int MAX_WAIT = 255;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Instr;
    logic        Zero;
    logic        MemReady;
    logic        PCWr;
    logic [1:0]  PCSel;
    logic        IRWr;
    logic        IorD;
    logic        MemRd;
    logic        MemWr;
    logic [3:0]  EXTType;
    logic        ALUSrcB;
    logic [3:0]  ALUOp;
    logic        RegWr;
    logic [1:0]  RegDst;
    logic [1:0]  WDSel;
    logic        Illegal;
    logic        BusErr;

    mc_ctrl #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk      (clk),
        .reset    (reset),
        .Instr    (Instr),
        .Zero     (Zero),
        .MemReady (MemReady),
        .PCWr     (PCWr),
        .PCSel    (PCSel),
        .IRWr     (IRWr),
        .IorD     (IorD),
        .MemRd    (MemRd),
        .MemWr    (MemWr),
        .EXTType  (EXTType),
        .ALUSrcB  (ALUSrcB),
        .ALUOp    (ALUOp),
        .RegWr    (RegWr),
        .RegDst   (RegDst),
        .WDSel    (WDSel),
        .Illegal  (Illegal),
        .BusErr   (BusErr)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_wr;
        logic [1:0] pc_sel;
        logic       ir_wr;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic [3:0] ext;
        logic       src_b;
        logic [3:0] alu;
        logic       reg_wr;
        logic [1:0] reg_dst;
        logic [1:0] wd_sel;
        logic       illegal;
        logic       bus_err;
    } outs_t;

    typedef struct {
        string tag;
        outs_t exp;
        outs_t mask;
    } sb_t;

    localparam outs_t FULL = '1;

    sb_t   sb[$];
    sb_t   s;
    outs_t obs;
    int    n_tests = 0;
    int    n_fail  = 0;
    logic  inv_en  = 1'b0;

    // Instruction-dependent fields expected from DECODE through WB.
    logic [3:0] cur_ext  = '0;
    logic [3:0] cur_alu  = '0;
    logic       cur_srcb = 1'b0;
    outs_t      cur_mask = '1;

    assign obs = {PCWr, PCSel, IRWr, IorD, MemRd, MemWr, EXTType, ALUSrcB,
                  ALUOp, RegWr, RegDst, WDSel, Illegal, BusErr};

    function automatic outs_t base();
        outs_t o;
        o       = '0;
        o.ext   = cur_ext;
        o.alu   = cur_alu;
        o.src_b = cur_srcb;
        return o;
    endfunction

    // In FETCH the instruction fields still reflect the previous instruction.
    function automatic outs_t fetch_mask();
        outs_t m;
        m       = '1;
        m.ext   = '0;
        m.alu   = '0;
        m.src_b = 1'b0;
        return m;
    endfunction

    always @(negedge clk) begin
        if (inv_en) begin
            n_tests++;
            assert (!(MemRd && MemWr) && !(RegWr && MemWr)) else begin
                n_fail++;
                $error("FAIL exclusive_ctrl: MemRd=%b MemWr=%b RegWr=%b, required no MemRd+MemWr or RegWr+MemWr",
                       MemRd, MemWr, RegWr);
            end
        end
        if (sb.size() != 0) begin
            s = sb.pop_front();
            n_tests++;
            assert ((obs & s.mask) === (s.exp & s.mask)) else begin
                n_fail++;
                $error("FAIL %s: got %h, required %h (mask %h)", s.tag, obs & s.mask, s.exp & s.mask, s.mask);
            end
        end
    end

    // One clock cycle: drive inputs, queue the expected outputs, advance.
    task automatic cyc(input logic mr, input logic z, input outs_t e, input outs_t m, input string tag);
        sb_t t;
        MemReady = mr;
        Zero     = z;
        t.tag    = tag;
        t.exp    = e;
        t.mask   = m;
        sb.push_back(t);
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic do_fetch(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] ext,
                            input logic [3:0] alu, input logic srcb, input logic alu_known,
                            input string nm);
        outs_t e;
        Instr    = {op, 20'hA5A5A, fn};
        e        = '0;
        e.mem_rd = 1'b1;
        e.ir_wr  = 1'b1;
        e.pc_wr  = 1'b1;
        cyc(1'b1, 1'b0, e, fetch_mask(), {nm, "/fetch"});
        // Garbage after the fetch edge exposes a late opcode latch.
        Instr    = 32'hFFFF_FFFF;
        cur_ext  = ext;
        cur_alu  = alu;
        cur_srcb = srcb;
        cur_mask = FULL;
        if (!alu_known) begin
            cur_mask.alu   = '0;
            cur_mask.src_b = 1'b0;
        end
    endtask

    task automatic run_alu(input logic [5:0] op, input logic [5:0] fn, input logic [3:0] ext,
                           input logic [3:0] alu, input logic srcb, input logic rtype,
                           input string nm);
        outs_t e;
        do_fetch(op, fn, ext, alu, srcb, 1'b1, nm);
        cyc(1'b0, 1'b0, base(), cur_mask, {nm, "/decode"});
        cyc(1'b0, 1'b0, base(), cur_mask, {nm, "/exec"});
        e         = base();
        e.reg_wr  = 1'b1;
        e.reg_dst = rtype ? 2'b01 : 2'b00;
        cyc(1'b0, 1'b0, e, cur_mask, {nm, "/wb"});
    endtask

    initial begin
        outs_t e;
        outs_t m;

        reset    = 1'b1;
        MemReady = 1'b0;
        Zero     = 1'b0;
        Instr    = '0;
        repeat (2) @(posedge clk);
        #1;
        // MemReady high during reset must not leak into any output.
        cyc(1'b1, 1'b0, '0, FULL, "reset_state");
        reset  = 1'b0;
        inv_en = 1'b1;

        // Register-immediate and register-register ALU instructions, 4 cycles each.
        run_alu(6'h0D, 6'h00, 4'b0000, 4'b0010, 1'b1, 1'b0, "ori");
        run_alu(6'h0F, 6'h00, 4'b0010, 4'b0011, 1'b1, 1'b0, "lui");
        run_alu(6'h00, 6'h21, 4'b0000, 4'b0000, 1'b0, 1'b1, "addu");
        run_alu(6'h00, 6'h23, 4'b0000, 4'b0001, 1'b0, 1'b1, "subu");

        // lw, memory ready at once: MEM in cycle 4, WB in cycle 5.
        do_fetch(6'h23, 6'h00, 4'b0001, 4'b0000, 1'b1, 1'b1, "lw");
        cyc(1'b0, 1'b0, base(), cur_mask, "lw/decode");
        cyc(1'b0, 1'b0, base(), cur_mask, "lw/exec");
        e = base(); e.iord = 1'b1; e.mem_rd = 1'b1;
        cyc(1'b1, 1'b0, e, cur_mask, "lw/mem");
        e = base(); e.reg_wr = 1'b1; e.wd_sel = 2'b01;
        cyc(1'b0, 1'b0, e, cur_mask, "lw/wb");

        // lw with a slow memory: request held across idle cycles.
        do_fetch(6'h23, 6'h00, 4'b0001, 4'b0000, 1'b1, 1'b1, "lw_slow");
        cyc(1'b0, 1'b0, base(), cur_mask, "lw_slow/decode");
        cyc(1'b0, 1'b0, base(), cur_mask, "lw_slow/exec");
        e = base(); e.iord = 1'b1; e.mem_rd = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, e, cur_mask, "lw_slow/mem_wait");
        cyc(1'b1, 1'b0, e, cur_mask, "lw_slow/mem_done");
        e = base(); e.reg_wr = 1'b1; e.wd_sel = 2'b01;
        cyc(1'b0, 1'b0, e, cur_mask, "lw_slow/wb");

        // sw: MEM in cycle 4, then straight back to FETCH.
        do_fetch(6'h2B, 6'h00, 4'b0001, 4'b0000, 1'b1, 1'b1, "sw");
        cyc(1'b0, 1'b0, base(), cur_mask, "sw/decode");
        cyc(1'b0, 1'b0, base(), cur_mask, "sw/exec");
        e = base(); e.iord = 1'b1; e.mem_wr = 1'b1;
        cyc(1'b1, 1'b0, e, cur_mask, "sw/mem");

        // beq taken and not taken.
        do_fetch(6'h04, 6'h00, 4'b0001, 4'b0001, 1'b0, 1'b1, "beq_taken");
        cyc(1'b0, 1'b0, base(), cur_mask, "beq_taken/decode");
        e = base(); e.pc_wr = 1'b1; e.pc_sel = 2'b01;
        cyc(1'b0, 1'b1, e, cur_mask, "beq_taken/exec");
        do_fetch(6'h04, 6'h00, 4'b0001, 4'b0001, 1'b0, 1'b1, "beq_not");
        cyc(1'b0, 1'b1, base(), cur_mask, "beq_not/decode");
        e = base(); e.pc_sel = 2'b01;
        cyc(1'b0, 1'b0, e, cur_mask, "beq_not/exec");

        // jal and j complete in DECODE.
        do_fetch(6'h03, 6'h00, 4'b0000, 4'b0000, 1'b0, 1'b0, "jal");
        e = base(); e.pc_wr = 1'b1; e.pc_sel = 2'b10; e.reg_wr = 1'b1; e.reg_dst = 2'b10; e.wd_sel = 2'b10;
        cyc(1'b0, 1'b0, e, cur_mask, "jal/decode");
        do_fetch(6'h02, 6'h00, 4'b0000, 4'b0000, 1'b0, 1'b0, "j");
        e = base(); e.pc_wr = 1'b1; e.pc_sel = 2'b10;
        cyc(1'b0, 1'b0, e, cur_mask, "j/decode");

        // jr completes in EXEC.
        do_fetch(6'h00, 6'h08, 4'b0000, 4'b0000, 1'b0, 1'b0, "jr");
        cyc(1'b0, 1'b0, base(), cur_mask, "jr/decode");
        e = base(); e.pc_wr = 1'b1; e.pc_sel = 2'b11;
        cyc(1'b0, 1'b0, e, cur_mask, "jr/exec");

        // Unsupported opcode and unsupported funct: Illegal pulse, no writes.
        do_fetch(6'h3F, 6'h00, 4'b0000, 4'b0000, 1'b0, 1'b0, "op3f");
        e = base(); e.illegal = 1'b1;
        cyc(1'b0, 1'b0, e, cur_mask, "op3f/decode");
        do_fetch(6'h00, 6'h2A, 4'b0000, 4'b0000, 1'b0, 1'b0, "fn2a");
        e = base(); e.illegal = 1'b1;
        cyc(1'b0, 1'b0, e, cur_mask, "fn2a/decode");

        // Fetch that never completes: BusErr on the MAX_WAIT-th idle cycle, retry.
        Instr = 32'hFFFF_FFFF;
        e = '0; e.mem_rd = 1'b1;
        for (int i = 1; i < MAX_WAIT; i++) cyc(1'b0, 1'b0, e, fetch_mask(), "fetch_wait");
        e.bus_err = 1'b1;
        cyc(1'b0, 1'b0, e, fetch_mask(), "fetch_timeout");
        run_alu(6'h00, 6'h21, 4'b0000, 4'b0000, 1'b0, 1'b1, "addu_retry");

        // sw that times out: BusErr once, write request gone next cycle.
        do_fetch(6'h2B, 6'h00, 4'b0001, 4'b0000, 1'b1, 1'b1, "sw_to");
        cyc(1'b0, 1'b0, base(), cur_mask, "sw_to/decode");
        cyc(1'b0, 1'b0, base(), cur_mask, "sw_to/exec");
        e = base(); e.iord = 1'b1; e.mem_wr = 1'b1;
        for (int i = 1; i < MAX_WAIT; i++) cyc(1'b0, 1'b0, e, cur_mask, "sw_to/mem_wait");
        e.bus_err = 1'b1;
        m = cur_mask; m.mem_wr = 1'b0; m.mem_rd = 1'b0;
        cyc(1'b0, 1'b0, e, m, "sw_to/buserr");
        e = '0; e.mem_rd = 1'b1;
        cyc(1'b0, 1'b0, e, fetch_mask(), "sw_to/back_to_fetch");

        // sw completing on the very cycle the counter hits the limit: no BusErr.
        do_fetch(6'h2B, 6'h00, 4'b0001, 4'b0000, 1'b1, 1'b1, "sw_edge");
        cyc(1'b0, 1'b0, base(), cur_mask, "sw_edge/decode");
        cyc(1'b0, 1'b0, base(), cur_mask, "sw_edge/exec");
        e = base(); e.iord = 1'b1; e.mem_wr = 1'b1;
        for (int i = 1; i < MAX_WAIT; i++) cyc(1'b0, 1'b0, e, cur_mask, "sw_edge/mem_wait");
        cyc(1'b1, 1'b0, e, cur_mask, "sw_edge/mem_done");
        e = '0; e.mem_rd = 1'b1;
        cyc(1'b0, 1'b0, e, fetch_mask(), "sw_edge/back_to_fetch");
        // Finish that pending fetch cleanly before the next directed block.
        e.ir_wr = 1'b1; e.pc_wr = 1'b1;
        Instr = {6'h3F, 26'h0};
        cyc(1'b1, 1'b0, e, fetch_mask(), "sw_edge/fetch_done");
        e = '0; e.illegal = 1'b1;
        cyc(1'b0, 1'b0, e, FULL, "sw_edge/illegal_decode");

        // Reset mid-MEM of sw: write request drops before the next clock edge.
        do_fetch(6'h2B, 6'h00, 4'b0001, 4'b0000, 1'b1, 1'b1, "sw_rst");
        cyc(1'b0, 1'b0, base(), cur_mask, "sw_rst/decode");
        cyc(1'b0, 1'b0, base(), cur_mask, "sw_rst/exec");
        e = base(); e.iord = 1'b1; e.mem_wr = 1'b1;
        cyc(1'b0, 1'b0, e, cur_mask, "sw_rst/mem");
        reset = 1'b1;
        cyc(1'b1, 1'b0, '0, FULL, "sw_rst/in_reset");
        reset = 1'b0;
        e = '0; e.mem_rd = 1'b1;
        cyc(1'b0, 1'b0, e, fetch_mask(), "sw_rst/after_release");
        run_alu(6'h0D, 6'h00, 4'b0000, 4'b0010, 1'b1, 1'b0, "ori_after_rst");

        inv_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
